// File: rtl/aes_ctrl_pkg.sv
// aes_ctrl_pkg: shared types, constants and word select for the AES request scheduler
package aes_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, WAIT, UNLOAD, RESP} state_t;
  localparam int WORDS = 4;
  typedef logic [127:0] block_t;
  function automatic logic [31:0] word(block_t b, logic [1:0] idx);
    return b[127 - 32*int'(idx) -: 32];
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter, one-hot grant favouring the requester that did not win last
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] gnt
);
  assign gnt[0] = en & req[0] & (~req[1] | last_grant);
  assign gnt[1] = en & req[1] & (~req[0] | ~last_grant);
endmodule

// File: rtl/aes_req_sched.sv
// aes_req_sched: shares one 32-bit-word AES core between two 128-bit requesters with a completion watchdog
module aes_req_sched
  import aes_ctrl_pkg::*;
#(
  parameter  int TIMEOUT = 64,
  localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_key,
  input  logic [127:0] req0_text,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_key,
  input  logic [127:0] req1_text,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [127:0] rsp_text,
  output logic         rsp_err,
  output logic         core_ld,
  output logic [31:0]  core_key,
  output logic [31:0]  core_text_in,
  input  logic [31:0]  core_text_out,
  input  logic         core_done,
  output logic         busy
);
  state_t state, nxt;
  logic [1:0] gnt, wcnt;
  logic [CNT_W-1:0] wdog;
  logic last_grant, id_q, err_q;
  block_t key_q, text_q, res_q;
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);
  // reset gates the grant so ready is 0 while rst is held, even with valid high
  rr_arb2 u_arb (
    .req        ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .en         (rst && state == IDLE),
    .gnt        (gnt)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = |gnt ? LOAD : IDLE;
      LOAD:    nxt = wcnt == 2'd3 ? WAIT : LOAD;
      WAIT:    nxt = core_done ? UNLOAD : (wdog == WDOG_LAST ? RESP : WAIT);
      UNLOAD:  nxt = (!core_done || wcnt == 2'd3) ? RESP : UNLOAD;
      RESP:    nxt = rsp_ready ? IDLE : RESP;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= 1'b1;
      wcnt       <= '0;
      wdog       <= '0;
      id_q       <= 1'b0;
      err_q      <= 1'b0;
      key_q      <= '0;
      text_q     <= '0;
      res_q      <= '0;
    end else begin
      case (state)
        IDLE: if (|gnt) begin
          key_q      <= gnt[1] ? req1_key : req0_key;
          text_q     <= gnt[1] ? req1_text : req0_text;
          id_q       <= gnt[1];
          last_grant <= gnt[1];
          wcnt       <= '0;
          res_q      <= '0;
          err_q      <= 1'b0;
        end
        LOAD: begin
          wcnt <= wcnt + 2'd1;
          wdog <= '0;
        end
        WAIT:
          if (core_done) begin
            res_q[127 -: 32] <= core_text_out;
            wcnt             <= 2'd1;
          end else if (wdog == WDOG_LAST) err_q <= 1'b1;
          else wdog <= wdog + CNT_W'(1);
        UNLOAD:
          if (core_done) begin
            res_q[127 - 32*int'(wcnt) -: 32] <= core_text_out;
            wcnt                             <= wcnt + 2'd1;
          end else begin
            err_q <= 1'b1;
            wcnt  <= '0;
          end
        default: ;
      endcase
    end
  end
  always_comb begin
    core_ld      = state == LOAD;
    core_key     = core_ld ? word(key_q, wcnt) : '0;
    core_text_in = core_ld ? word(text_q, wcnt) : '0;
    req0_ready   = gnt[0];
    req1_ready   = gnt[1];
    rsp_valid    = state == RESP;
    rsp_id       = id_q;
    rsp_err      = err_q;
    rsp_text     = res_q;
    busy         = state != IDLE;
  end
endmodule
